// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO controller: output pins with set/clear, synchronised and debounced inputs,
// edge status with interrupt. Define MMIO_GPIO_TOGGLE_EN to add OUT_TGL (0x09) and OUT_PULSE (0x0A).
module mmio_gpio_ctrl #(
    parameter int N_OUT           = 16,
    parameter int N_IN            = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [N_OUT-1:0] gpio_out,
    input  logic [N_IN-1:0]  gpio_in,
    input  logic             i_mmio_enable,
    input  logic             i_mmio_wen,
    input  logic [7:0]       i_mmio_addr,
    input  logic [31:0]      i_mmio_data_in,
    output logic [31:0]      o_mmio_data_out,
    output logic             o_irq
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [7:0] A_OUT     = 8'h01;
    localparam logic [7:0] A_SET     = 8'h02;
    localparam logic [7:0] A_CLR     = 8'h03;
    localparam logic [7:0] A_IN      = 8'h04;
    localparam logic [7:0] A_STAT    = 8'h05;
    localparam logic [7:0] A_IRQ_EN  = 8'h06;
    localparam logic [7:0] A_RISE_EN = 8'h07;
    localparam logic [7:0] A_FALL_EN = 8'h08;
`ifdef MMIO_GPIO_TOGGLE_EN
    localparam logic [7:0]    A_TGL     = 8'h09;
    localparam logic [7:0]    A_PULSE   = 8'h0A;
    localparam logic [CW-1:0] PULSE_LEN = CW'(DEBOUNCE_CYCLES);
`endif

    logic             wr_en;
    logic             rd_en;
    logic [N_OUT-1:0] wdata_out;
    logic [N_IN-1:0]  wdata_in;
    logic             unused_data;

    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  sync_p0, sync_p1;
    logic [N_IN-1:0]  deb_q, deb_d;
    logic [CW-1:0]    cnt_q [N_IN];
    logic [CW-1:0]    cnt_d [N_IN];
    logic [N_IN-1:0]  stat_q, stat_d;
    logic [N_IN-1:0]  edge_set;
    logic [N_IN-1:0]  irq_en_q, rise_en_q, fall_en_q;
    logic [31:0]      rdata;
`ifdef MMIO_GPIO_TOGGLE_EN
    logic [N_OUT-1:0] pmask_q, pmask_d;
    logic [CW-1:0]    ptmr_q, ptmr_d;
`endif

    assign wr_en       = i_mmio_enable & i_mmio_wen;
    assign rd_en       = i_mmio_enable & ~i_mmio_wen;
    assign wdata_out   = i_mmio_data_in[N_OUT-1:0];
    assign wdata_in    = i_mmio_data_in[N_IN-1:0];
    assign unused_data = ^i_mmio_data_in;
    assign gpio_out    = out_q;

    // Stage p1 -> debounce: a bit flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_p1[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync_p1[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Events are taken from the debounced transition itself, so status sets on the same edge
    assign edge_set = (deb_d & ~deb_q & rise_en_q) | (~deb_d & deb_q & fall_en_q);

    always_comb begin
        stat_d = stat_q;
        if (wr_en && i_mmio_addr == A_STAT) begin
            stat_d = stat_q & ~wdata_in;
        end
        stat_d = stat_d | edge_set;
    end

    always_comb begin
        out_d = out_q;
`ifdef MMIO_GPIO_TOGGLE_EN
        pmask_d = pmask_q;
        ptmr_d  = ptmr_q;
        if (ptmr_q == CW'(1)) begin
            out_d   = out_q & ~pmask_q;
            pmask_d = '0;
            ptmr_d  = '0;
        end else if (ptmr_q != '0) begin
            ptmr_d = ptmr_q - CW'(1);
        end
`endif
        if (wr_en) begin
            case (i_mmio_addr)
                A_OUT: out_d = wdata_out;
                A_SET: out_d = out_d | wdata_out;
                A_CLR: out_d = out_d & ~wdata_out;
`ifdef MMIO_GPIO_TOGGLE_EN
                A_TGL: out_d = out_d ^ wdata_out;
                A_PULSE: begin
                    // A restart keeps the bits already pulsing, so expiry is not applied here
                    out_d   = out_q | wdata_out;
                    pmask_d = pmask_q | wdata_out;
                    ptmr_d  = PULSE_LEN;
                end
`endif
                default: ;
            endcase
`ifdef MMIO_GPIO_TOGGLE_EN
            if (i_mmio_addr == A_OUT) pmask_d = '0;
            if (i_mmio_addr == A_CLR) pmask_d = pmask_d & ~wdata_out;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        case (i_mmio_addr)
            A_OUT:     rdata = 32'(out_q);
            A_IN:      rdata = 32'(deb_q);
            A_STAT:    rdata = 32'(stat_q);
            A_IRQ_EN:  rdata = 32'(irq_en_q);
            A_RISE_EN: rdata = 32'(rise_en_q);
            A_FALL_EN: rdata = 32'(fall_en_q);
            default:   rdata = '0;
        endcase
    end

    // Stage p0/p1: two-flop synchroniser, then registered state and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0         <= '0;
            sync_p1         <= '0;
            deb_q           <= '0;
            cnt_q           <= '{default: '0};
            out_q           <= '0;
            stat_q          <= '0;
            irq_en_q        <= '0;
            rise_en_q       <= '0;
            fall_en_q       <= '0;
            o_mmio_data_out <= '0;
            o_irq           <= 1'b0;
`ifdef MMIO_GPIO_TOGGLE_EN
            pmask_q         <= '0;
            ptmr_q          <= '0;
`endif
        end else begin
            sync_p0 <= gpio_in;
            sync_p1 <= sync_p0;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            stat_q  <= stat_d;
            o_irq   <= |(stat_q & irq_en_q);
`ifdef MMIO_GPIO_TOGGLE_EN
            pmask_q <= pmask_d;
            ptmr_q  <= ptmr_d;
`endif
            if (wr_en) begin
                case (i_mmio_addr)
                    A_IRQ_EN:  irq_en_q  <= wdata_in;
                    A_RISE_EN: rise_en_q <= wdata_in;
                    A_FALL_EN: fall_en_q <= wdata_in;
                    default: ;
                endcase
            end
            if (rd_en) begin
                o_mmio_data_out <= rdata;
            end
        end
    end

endmodule
